// File: rtl/siganfu_machine_gun.sv
// Fire-control FSM for the Siganfu turret gun: gates fire on lock + IFF, counts rounds
// and spare magazines, sequences reload/cooldown and latches DOWNFALL when ammo is spent.
module siganfu_machine_gun #(
  parameter int unsigned MAG_SIZE        = 25,
  parameter int unsigned SPARE_MAGS      = 1,
  parameter int unsigned RELOAD_CYCLES   = 5,
  parameter int unsigned COOLDOWN_CYCLES = 10,
  parameter int unsigned CRIT_ROUNDS     = 5
) (
  input  logic       sysclk,
  input  logic       reboot,
  input  logic       target_locked,
  input  logic       is_enemy,
  input  logic       fire_command,
  input  logic       firing_mode,
  input  logic       overheat_sensor,
  output logic [2:0] current_state,
  output logic       criticality_alert,
  output logic       fire_trigger
);

  localparam int unsigned RW   = $clog2(MAG_SIZE + 1);
  localparam int unsigned SW   = (SPARE_MAGS > 0) ? $clog2(SPARE_MAGS + 1) : 1;
  localparam int unsigned CMAX = (RELOAD_CYCLES > COOLDOWN_CYCLES) ? RELOAD_CYCLES
                                                                    : COOLDOWN_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_FIRING   = 3'd2,
    ST_RELOAD   = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_DOWNFALL = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rounds_q, rounds_d;
  logic [SW-1:0]   spares_q, spares_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            trig_q, trig_d;
  logic            alert_q, alert_d;
  logic            ok;

  assign ok = is_enemy & target_locked;

  // State and counter registers
  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state_q  <= ST_IDLE;
      rounds_q <= RW'(MAG_SIZE);
      spares_q <= SW'(SPARE_MAGS);
      cnt_q    <= '0;
      press_q  <= 1'b0;
      trig_q   <= 1'b0;
      alert_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rounds_q <= rounds_d;
      spares_q <= spares_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      trig_q   <= trig_d;
      alert_q  <= alert_d;
    end
  end

  // Next-state, counter updates and registered-output inputs
  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    spares_d = spares_q;
    cnt_d    = cnt_q;
    press_d  = press_q;
    trig_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ok) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (overheat_sensor) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
        end else if (!ok) begin
          state_d = ST_IDLE;
        end else if (fire_command) begin
          state_d = ST_FIRING;
        end
      end
      ST_FIRING: begin
        if (overheat_sensor) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          press_d = 1'b0;
        end else if (!ok) begin
          state_d = ST_IDLE;
          press_d = 1'b0;
        end else if (!fire_command) begin
          state_d = ST_LOCKED;
          press_d = 1'b0;
        end else if ((firing_mode || !press_q) && (rounds_q != '0)) begin
          trig_d   = 1'b1;
          rounds_d = rounds_q - RW'(1);
          press_d  = 1'b1;
          // Last round of the magazine leaves FIRING on the same edge
          if (rounds_q == RW'(1)) begin
            press_d = 1'b0;
            cnt_d   = '0;
            state_d = (spares_q != '0) ? ST_RELOAD : ST_DOWNFALL;
          end
        end
      end
      ST_RELOAD: begin
        if (cnt_q == CW'(RELOAD_CYCLES - 1)) begin
          rounds_d = RW'(MAG_SIZE);
          if (spares_q != '0) spares_d = spares_q - SW'(1);
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COOLDOWN: begin
        // Counter saturates at the minimum dwell; exit waits for the sensor to clear
        if (cnt_q >= CW'(COOLDOWN_CYCLES - 1)) begin
          if (!overheat_sensor) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DOWNFALL: begin
        state_d = ST_DOWNFALL;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        press_d = 1'b0;
      end
    endcase

    alert_d = (state_d == ST_DOWNFALL) ||
              ((spares_d == '0) && (rounds_d <= RW'(CRIT_ROUNDS)));
  end

  assign current_state     = state_q;
  assign criticality_alert = alert_q;
  assign fire_trigger      = trig_q;

endmodule

// File: tb/tb_siganfu_machine_gun.sv
// Self-checking bench for siganfu_machine_gun: directed scenarios plus random stimulus,
// compared cycle by cycle against an integer-level behavioural model.
module tb_siganfu_machine_gun;

  localparam int MAG   = 25;
  localparam int SPARE = 1;
  localparam int RLD   = 5;
  localparam int COOL  = 10;
  localparam int CRIT  = 5;

  logic       sysclk = 1'b0;
  logic       reboot, target_locked, is_enemy, fire_command, firing_mode, overheat_sensor;
  logic [2:0] current_state;
  logic       criticality_alert, fire_trigger;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Model: state number, rounds, spares, edges spent in the current timed state
  int m_state, m_rounds, m_spares, m_elapsed;
  bit m_shot, m_trig, m_alert;

  always #5 sysclk = ~sysclk;

  siganfu_machine_gun dut (
    .sysclk            (sysclk),
    .reboot            (reboot),
    .target_locked     (target_locked),
    .is_enemy          (is_enemy),
    .fire_command      (fire_command),
    .firing_mode       (firing_mode),
    .overheat_sensor   (overheat_sensor),
    .current_state     (current_state),
    .criticality_alert (criticality_alert),
    .fire_trigger      (fire_trigger)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit rb, tl, en, fc, md, oh);
    bit ok;
    ok = tl & en;
    m_trig = 1'b0;
    if (rb) begin
      m_state = 0; m_rounds = MAG; m_spares = SPARE; m_elapsed = 0; m_shot = 1'b0;
      m_alert = 1'b0;
    end else begin
      case (m_state)
        0: if (ok) m_state = 1;
        1: begin
          if (oh) begin m_state = 4; m_elapsed = 0; end
          else if (!ok) m_state = 0;
          else if (fc) m_state = 2;
        end
        2: begin
          if (oh) begin m_state = 4; m_elapsed = 0; m_shot = 1'b0; end
          else if (!ok) begin m_state = 0; m_shot = 1'b0; end
          else if (!fc) begin m_state = 1; m_shot = 1'b0; end
          else if (md || !m_shot) begin
            m_shot = 1'b1;
            m_rounds--;
            m_trig = 1'b1;
            if (m_rounds == 0) begin
              m_shot = 1'b0;
              m_elapsed = 0;
              m_state = (m_spares > 0) ? 3 : 5;
            end
          end
        end
        3: begin
          m_elapsed++;
          if (m_elapsed == RLD) begin
            m_rounds = MAG; m_spares--; m_elapsed = 0; m_state = 0;
          end
        end
        4: begin
          m_elapsed++;
          if (m_elapsed >= COOL && !oh) begin m_state = 0; m_elapsed = 0; end
        end
        default: ;
      endcase
      m_alert = (m_state == 5) || (m_spares == 0 && m_rounds <= CRIT);
    end
  endtask

  task automatic cyc(input bit rb, tl, en, fc, md, oh, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      reboot = rb; target_locked = tl; is_enemy = en;
      fire_command = fc; firing_mode = md; overheat_sensor = oh;
      model_step(rb, tl, en, fc, md, oh);
      @(posedge sysclk);
      #1;
      chk("state", int'(current_state), m_state);
      chk("alert", int'(criticality_alert), int'(m_alert));
      chk("trigger", int'(fire_trigger), int'(m_trig));
      if (fire_trigger) pulses++;
    end
  endtask

  initial begin
    reboot = 1'b0; target_locked = 1'b0; is_enemy = 1'b0;
    fire_command = 1'b0; firing_mode = 1'b0; overheat_sensor = 1'b0;

    // Reset then lock
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("reset_state", int'(current_state), 0);
    cyc(0, 1, 1, 0, 0, 0, 1);
    chk("lock_state", int'(current_state), 1);

    // Automatic burst through both magazines into DOWNFALL, then hold
    pulses = 0;
    cyc(0, 1, 1, 1, 1, 0, 170);
    chk("auto_pulses", pulses, 2 * MAG);
    chk("downfall_state", int'(current_state), 5);

    // Reboot out of DOWNFALL restores a full magazine
    cyc(1, 1, 1, 1, 1, 0, 1);
    chk("reboot_alert", int'(criticality_alert), 0);
    pulses = 0;
    cyc(0, 1, 1, 1, 1, 0, 27);
    chk("refill_pulses", pulses, MAG);

    // Single-shot presses
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 1);
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      cyc(0, 1, 1, 1, 0, 0, 6);
      cyc(0, 1, 1, 0, 0, 0, 2);
    end
    chk("single_pulses", pulses, 3);

    // Overheat mid-burst, sensor cleared after three cycles
    cyc(0, 1, 1, 1, 1, 0, 4);
    cyc(0, 1, 1, 1, 1, 1, 3);
    cyc(0, 1, 1, 1, 1, 0, 12);

    // Drop IFF mid-burst
    cyc(0, 1, 1, 1, 1, 0, 5);
    cyc(0, 1, 0, 1, 1, 0, 3);

    // Reboot in the middle of a reload
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 1, 0, 29);
    chk("in_reload", int'(current_state), 3);
    cyc(1, 1, 1, 1, 1, 0, 1);
    pulses = 0;
    cyc(0, 1, 1, 1, 1, 0, 27);
    chk("reload_reboot_pulses", pulses, MAG);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 4) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 24) == 0),
          1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
